instr_ram_loader: RTL and testbench

- Writer side of the instruction-RAM interface; the CPU fetch path is the reader.
- Receives a program as a byte stream, packs the bytes into 32-bit instruction words and writes them into instruction RAM. Writes use the same port triple the fetch path drives: Enable, RW (1 = read, 0 = write), 16-bit Address.
- Holds the CPU off (cpu_hold) while a load is in progress, then reports done or error.

---
 rtl/instr_ram_loader_pkg.sv | 20 ++
 rtl/instr_ram_loader_byte_packer.sv | 50 +++++
 rtl/instr_ram_loader.sv | 131 +++++++++++++
 tb/tb_instr_ram_loader.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_ram_loader_pkg.sv
// Shared definitions for the instruction-RAM loader and the RAM/fetch side.
package instr_ram_loader_pkg;

  // Instruction word width written into instruction RAM.
  localparam int unsigned INSTR_W = 32;

  // RW encoding on the shared RAM port triple (Enable, RW, Address).
  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  // Loader control states.
  typedef enum logic [2:0] {
    IDLE,
    COLLECT,
    WRITE,
    DONE,
    ERROR
  } state_t;

endpackage

// File: rtl/instr_ram_loader_byte_packer.sv
// Packs four bytes, big-endian, into one instruction word.
// The first byte lands in [31:24] and the fourth byte in [7:0].
module instr_ram_loader_byte_packer
  import instr_ram_loader_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  input  logic               accept,
  input  logic [7:0]         byte_in,
  output logic [INSTR_W-1:0] word_next,
  output logic               word_full
);

  logic [1:0]         index_q, index_d;
  logic [INSTR_W-1:0] word_q, word_d;

  // Drop the incoming byte into its lane and advance the byte index.
  always_comb begin
    index_d   = index_q;
    word_d    = word_q;
    word_next = word_q;
    unique case (index_q)
      2'd0:    word_next[31:24] = byte_in;
      2'd1:    word_next[23:16] = byte_in;
      2'd2:    word_next[15:8]  = byte_in;
      default: word_next[7:0]   = byte_in;
    endcase
    word_full = accept && (index_q == 2'd3);
    if (clear) begin
      index_d = '0;
      word_d  = '0;
    end else if (accept) begin
      index_d = index_q + 2'd1;
      word_d  = word_next;
    end
  end

  // Index and partial-word registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      index_q <= '0;
      word_q  <= '0;
    end else begin
      index_q <= index_d;
      word_q  <= word_d;
    end
  end

endmodule

// File: rtl/instr_ram_loader.sv
// Instruction-RAM loader: turns a program byte stream into 32-bit word
// writes on the RAM port the fetch path uses, holding the CPU off meanwhile.
module instr_ram_loader
  import instr_ram_loader_pkg::*;
#(
  parameter int unsigned       ADDR_W     = 16,
  parameter logic [ADDR_W-1:0] START_ADDR = '0,
  parameter int unsigned       MAX_WORDS  = 16
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               start,
  input  logic               byte_valid,
  input  logic [7:0]         byte_data,
  input  logic               byte_last,
  output logic               byte_ready,
  output logic               ram_enable,
  output logic               ram_rw,
  output logic [ADDR_W-1:0]  ram_address,
  output logic [INSTR_W-1:0] ram_data,
  output logic               cpu_hold,
  output logic               busy,
  output logic               done,
  output logic               error,
  output logic [ADDR_W-1:0]  word_count
);

  localparam logic [ADDR_W-1:0] MAX_WORDS_C = ADDR_W'(MAX_WORDS);

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  word_count_q, word_count_d;
  logic [ADDR_W-1:0]  ram_addr_q, ram_addr_d;
  logic [INSTR_W-1:0] ram_data_q, ram_data_d;
  logic               last_seen_q, last_seen_d;
  logic [ADDR_W-1:0]  count_inc;

  logic               accept;
  logic               pk_clear;
  logic               pk_full;
  logic [INSTR_W-1:0] pk_word_next;

  assign accept = byte_valid && byte_ready;

  instr_ram_loader_byte_packer u_packer (
    .clk       (Clk),
    .reset     (Reset),
    .clear     (pk_clear),
    .accept    (accept),
    .byte_in   (byte_data),
    .word_next (pk_word_next),
    .word_full (pk_full)
  );

  // Next-state logic; the write address/data are captured on the fourth
  // byte so they are stable during WRITE and hold afterwards.
  always_comb begin
    state_d      = state_q;
    word_count_d = word_count_q;
    ram_addr_d   = ram_addr_q;
    ram_data_d   = ram_data_q;
    last_seen_d  = last_seen_q;
    pk_clear     = 1'b0;
    count_inc    = word_count_q + 1'b1;
    unique case (state_q)
      IDLE, DONE, ERROR: begin
        if (start) begin
          state_d      = COLLECT;
          word_count_d = '0;
          last_seen_d  = 1'b0;
          pk_clear     = 1'b1;
        end
      end
      COLLECT: begin
        if (accept) begin
          if (pk_full) begin
            state_d     = WRITE;
            last_seen_d = byte_last;
            ram_addr_d  = START_ADDR + word_count_q;
            ram_data_d  = pk_word_next;
          end else if (byte_last) begin
            state_d  = ERROR;
            pk_clear = 1'b1;
          end
        end
      end
      WRITE: begin
        word_count_d = count_inc;
        if (last_seen_q) begin
          state_d = DONE;
        end else if (count_inc == MAX_WORDS_C) begin
          state_d = ERROR;
        end else begin
          state_d = COLLECT;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, counter and RAM-port registers.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q      <= IDLE;
      word_count_q <= '0;
      ram_addr_q   <= '0;
      ram_data_q   <= '0;
      last_seen_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      word_count_q <= word_count_d;
      ram_addr_q   <= ram_addr_d;
      ram_data_q   <= ram_data_d;
      last_seen_q  <= last_seen_d;
    end
  end

  // Output decode from the registered state.
  always_comb begin
    byte_ready  = (state_q == COLLECT);
    ram_enable  = (state_q == WRITE);
    ram_rw      = (state_q == WRITE) ? RW_WRITE : RW_READ;
    busy        = (state_q == COLLECT) || (state_q == WRITE);
    cpu_hold    = (state_q == COLLECT) || (state_q == WRITE) || (state_q == ERROR);
    done        = (state_q == DONE);
    error       = (state_q == ERROR);
    ram_address = ram_addr_q;
    ram_data    = ram_data_q;
    word_count  = word_count_q;
  end

endmodule

// File: tb/tb_instr_ram_loader.sv
// Self-checking bench: dut0 uses default parameters, dut1 has MAX_WORDS=2
// and START_ADDR=FFFF. Byte inputs are shared; each DUT has its own start.
module tb_instr_ram_loader;

  logic        Clk;
  logic        Reset;
  logic        start0, start1;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_last;

  logic        byte_ready0, ram_enable0, ram_rw0, cpu_hold0, busy0, done0, error0;
  logic [15:0] ram_address0, word_count0;
  logic [31:0] ram_data0;
  logic        byte_ready1, ram_enable1, ram_rw1, cpu_hold1, busy1, done1, error1;
  logic [15:0] ram_address1, word_count1;
  logic [31:0] ram_data1;

  int errors = 0;
  int checks = 0;
  int writes0 = 0;
  int writes1 = 0;
  logic [47:0] q0[$];
  logic [47:0] q1[$];

  typedef struct {
    logic [31:0] word;
    int          last_at;
    logic        exp_done;
    logic        exp_error;
    logic [15:0] exp_count;
    int          exp_writes;
  } vec_t;

  vec_t vecs[5];

  instr_ram_loader dut0 (
    .Clk(Clk), .Reset(Reset), .start(start0),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_last(byte_last),
    .byte_ready(byte_ready0), .ram_enable(ram_enable0), .ram_rw(ram_rw0),
    .ram_address(ram_address0), .ram_data(ram_data0), .cpu_hold(cpu_hold0),
    .busy(busy0), .done(done0), .error(error0), .word_count(word_count0)
  );

  instr_ram_loader #(.ADDR_W(16), .START_ADDR(16'hFFFF), .MAX_WORDS(2)) dut1 (
    .Clk(Clk), .Reset(Reset), .start(start1),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_last(byte_last),
    .byte_ready(byte_ready1), .ram_enable(ram_enable1), .ram_rw(ram_rw1),
    .ram_address(ram_address1), .ram_data(ram_data1), .cpu_hold(cpu_hold1),
    .busy(busy1), .done(done1), .error(error1), .word_count(word_count1)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required finish earlier");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic pulse_start(input int d);
    if (d == 0) start0 = 1'b1; else start1 = 1'b1;
    tick();
    start0 = 1'b0;
    start1 = 1'b0;
  endtask

  // Present one byte and hold it until the selected DUT accepts it.
  task automatic send_byte(input int d, input logic [7:0] b, input logic last);
    bit got;
    got        = 1'b0;
    byte_valid = 1'b1;
    byte_data  = b;
    byte_last  = last;
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge Clk);
      got = (d == 0) ? byte_ready0 : byte_ready1;
      tick();
    end
    byte_valid = 1'b0;
    byte_last  = 1'b0;
    chk("byte_accept_timeout", {63'd0, got}, 64'd1);
  endtask

  // Send a word's bytes up to last_at (4 = no byte_last); expected write is
  // queued just before the fourth byte goes out.
  task automatic send_word(input int d, input logic [15:0] addr, input logic [31:0] w,
                           input int last_at, input int gap);
    logic [7:0] b;
    for (int k = 0; k < 4; k++) begin
      if (k > last_at) break;
      b = w[31-8*k -: 8];
      if (k == 3) begin
        if (d == 0) q0.push_back({addr, w}); else q1.push_back({addr, w});
      end
      send_byte(d, b, k == last_at);
      if (k == 1 && gap > 0) repeat (gap) tick();
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    @(negedge Clk);
    chk({tag, "_ready0"}, {63'd0, byte_ready0}, 64'd0);
    chk({tag, "_en0"},    {63'd0, ram_enable0}, 64'd0);
    chk({tag, "_rw0"},    {63'd0, ram_rw0}, 64'd1);
    chk({tag, "_addr0"},  {48'd0, ram_address0}, 64'd0);
    chk({tag, "_data0"},  {32'd0, ram_data0}, 64'd0);
    chk({tag, "_hold0"},  {63'd0, cpu_hold0}, 64'd0);
    chk({tag, "_busy0"},  {63'd0, busy0}, 64'd0);
    chk({tag, "_flags0"}, {62'd0, done0, error0}, 64'd0);
    chk({tag, "_count0"}, {48'd0, word_count0}, 64'd0);
  endtask

  initial begin
    int wbase;
    vecs[0] = '{32'hE1A00008, 3, 1'b1, 1'b0, 16'd1, 1};
    vecs[1] = '{32'hDEADBEEF, 0, 1'b0, 1'b1, 16'd0, 0};
    vecs[2] = '{32'h12345678, 1, 1'b0, 1'b1, 16'd0, 0};
    vecs[3] = '{32'hCAFEF00D, 2, 1'b0, 1'b1, 16'd0, 0};
    vecs[4] = '{32'h00FF00FF, 3, 1'b1, 1'b0, 16'd1, 1};

    Reset = 1'b1; start0 = 1'b0; start1 = 1'b0;
    byte_valid = 1'b0; byte_data = '0; byte_last = 1'b0;
    repeat (3) tick();
    Reset = 1'b0;

    // Reset state of both instances
    check_idle_outputs("rst");
    chk("rst_ready1", {63'd0, byte_ready1}, 64'd0);
    chk("rst_en_rw1", {62'd0, ram_enable1, ram_rw1}, 64'd1);
    chk("rst_addr_data1", {16'd0, ram_address1, ram_data1}, 64'd0);
    chk("rst_status1", {60'd0, cpu_hold1, busy1, done1, error1}, 64'd0);
    chk("rst_count1", {48'd0, word_count1}, 64'd0);
    tick();

    // Write monitor for both instances
    fork
      forever begin
        logic [47:0] e;
        @(negedge Clk);
        if (ram_enable0) begin
          writes0++;
          chk("wr0_rw", {63'd0, ram_rw0}, 64'd0);
          if (q0.size() == 0) begin
            checks++; errors++;
            $display("FAIL wr0_unexpected: got write addr=%h data=%h, required no write",
                     ram_address0, ram_data0);
          end else begin
            e = q0.pop_front();
            chk("wr0_addr_data", {16'd0, ram_address0, ram_data0}, {16'd0, e});
          end
        end
        if (ram_enable1) begin
          writes1++;
          chk("wr1_rw", {63'd0, ram_rw1}, 64'd0);
          if (q1.size() == 0) begin
            checks++; errors++;
            $display("FAIL wr1_unexpected: got write addr=%h data=%h, required no write",
                     ram_address1, ram_data1);
          end else begin
            e = q1.pop_front();
            chk("wr1_addr_data", {16'd0, ram_address1, ram_data1}, {16'd0, e});
          end
        end
      end
    join_none

    // Start latency: byte_ready the cycle after start is sampled
    pulse_start(0);
    @(negedge Clk);
    chk("start_ready", {61'd0, byte_ready0, busy0, cpu_hold0}, 64'd7);
    tick();

    // Single-word loads with byte_last at various byte positions
    for (int v = 0; v < 5; v++) begin
      wbase = writes0;
      if (v > 0) pulse_start(0);
      send_word(0, 16'h0000, vecs[v].word, vecs[v].last_at, 0);
      repeat (3) tick();
      @(negedge Clk);
      chk($sformatf("vec%0d_done", v),   {63'd0, done0},  {63'd0, vecs[v].exp_done});
      chk($sformatf("vec%0d_error", v),  {63'd0, error0}, {63'd0, vecs[v].exp_error});
      chk($sformatf("vec%0d_hold", v),   {62'd0, cpu_hold0, busy0}, {62'd0, vecs[v].exp_error, 1'b0});
      chk($sformatf("vec%0d_count", v),  {48'd0, word_count0}, {48'd0, vecs[v].exp_count});
      chk($sformatf("vec%0d_writes", v), 64'(writes0 - wbase), 64'(vecs[v].exp_writes));
      tick();
    end

    // Three words with a 3-cycle byte_valid gap mid-word
    wbase = writes0;
    pulse_start(0);
    send_word(0, 16'h0000, 32'h11223344, 4, 0);
    send_word(0, 16'h0001, 32'h55667788, 4, 3);
    send_word(0, 16'h0002, 32'h99AABBCC, 3, 0);
    repeat (3) tick();
    @(negedge Clk);
    chk("three_done", {61'd0, done0, error0, cpu_hold0}, 64'd4);
    chk("three_count", {48'd0, word_count0}, 64'd3);
    chk("three_writes", 64'(writes0 - wbase), 64'd3);
    tick();

    // Premature byte_last on the 2nd byte of word 1
    wbase = writes0;
    pulse_start(0);
    send_word(0, 16'h0000, 32'hA1B2C3D4, 4, 0);
    send_byte(0, 8'hEE, 1'b0);
    send_byte(0, 8'hFF, 1'b1);
    repeat (3) tick();
    @(negedge Clk);
    chk("premature_flags", {61'd0, done0, error0, cpu_hold0}, 64'd3);
    chk("premature_count", {48'd0, word_count0}, 64'd1);
    chk("premature_writes", 64'(writes0 - wbase), 64'd1);
    tick();

    // Overflow on dut1: no byte_last, ready must stay low after 8th byte
    wbase = writes1;
    pulse_start(1);
    send_word(1, 16'hFFFF, 32'h01020304, 4, 0);
    send_word(1, 16'h0000, 32'h05060708, 4, 0);
    byte_valid = 1'b1;
    byte_data  = 8'h09;
    for (int n = 0; n < 4; n++) begin
      @(negedge Clk);
      chk($sformatf("ovf_ready_%0d", n), {63'd0, byte_ready1}, 64'd0);
      tick();
    end
    byte_valid = 1'b0;
    @(negedge Clk);
    chk("ovf_flags", {60'd0, done1, error1, cpu_hold1, busy1}, 64'd6);
    chk("ovf_count", {48'd0, word_count1}, 64'd2);
    chk("ovf_writes", 64'(writes1 - wbase), 64'd2);
    tick();

    // Address wrap on dut1: FFFF then 0000, byte_last on the 8th byte
    wbase = writes1;
    pulse_start(1);
    send_word(1, 16'hFFFF, 32'hDEAD0001, 4, 0);
    send_word(1, 16'h0000, 32'hBEEF0002, 3, 0);
    repeat (3) tick();
    @(negedge Clk);
    chk("wrap_flags", {61'd0, done1, error1, cpu_hold1}, 64'd4);
    chk("wrap_count", {48'd0, word_count1}, 64'd2);
    chk("wrap_writes", 64'(writes1 - wbase), 64'd2);
    tick();

    // start during COLLECT is ignored
    wbase = writes0;
    pulse_start(0);
    send_byte(0, 8'hAA, 1'b0);
    send_byte(0, 8'hBB, 1'b0);
    pulse_start(0);
    send_byte(0, 8'hCC, 1'b0);
    q0.push_back({16'h0000, 32'hAABBCCDD});
    send_byte(0, 8'hDD, 1'b1);
    repeat (3) tick();
    @(negedge Clk);
    chk("ign_start_done", {63'd0, done0}, 64'd1);
    chk("ign_start_count", {48'd0, word_count0}, 64'd1);
    chk("ign_start_writes", 64'(writes0 - wbase), 64'd1);
    tick();

    // Reset mid-word, then a fresh load from START_ADDR
    pulse_start(0);
    send_byte(0, 8'h77, 1'b0);
    send_byte(0, 8'h66, 1'b0);
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    check_idle_outputs("midrst");
    tick();
    wbase = writes0;
    pulse_start(0);
    send_word(0, 16'h0000, 32'h0BADC0DE, 3, 0);
    repeat (3) tick();
    @(negedge Clk);
    chk("after_rst_done", {63'd0, done0}, 64'd1);
    chk("after_rst_count", {48'd0, word_count0}, 64'd1);
    chk("after_rst_writes", 64'(writes0 - wbase), 64'd1);

    repeat (3) tick();
    chk("q0_drained", 64'(q0.size()), 64'd0);
    chk("q1_drained", 64'(q1.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
